// File: rtl/seg_anim_pkg.sv
// Shared types and helpers for the segment chase monitor.
package seg_anim_pkg;

  localparam int SEG_N = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    HOLD,
    FWD,
    REV,
    BLANK,
    BAD
  } step_e;

  // One position clockwise: A->B ... F->A.
  function automatic logic [5:0] rotl6(input logic [5:0] v);
    return {v[4:0], v[5]};
  endfunction

  // One position counter-clockwise: B->A ... A->F.
  function automatic logic [5:0] rotr6(input logic [5:0] v);
    return {v[0], v[5:1]};
  endfunction

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < SEG_N; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_anim_monitor_if.sv
// Segment bus plus monitor status outputs.
interface seg_anim_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       io_segAtoF;
  logic             io_clearErr;
  logic [2:0]       io_position;
  logic             io_posValid;
  logic             io_stepStrobe;
  logic             io_dirCW;
  logic             io_locked;
  logic             io_fault;
  logic             io_stalled;
  logic [CNT_W-1:0] io_stepPeriod;

  modport master (
    output io_segAtoF, io_clearErr,
    input  io_position, io_posValid, io_stepStrobe, io_dirCW,
    input  io_locked, io_fault, io_stalled, io_stepPeriod
  );

  modport slave (
    input  io_segAtoF, io_clearErr,
    output io_position, io_posValid, io_stepStrobe, io_dirCW,
    output io_locked, io_fault, io_stalled, io_stepPeriod
  );
endinterface

// File: rtl/seg_step_classifier.sv
// Combinational classification of one sample pair into a step class.
module seg_step_classifier
  import seg_anim_pkg::*;
(
  input  logic [5:0] cur,
  input  logic [5:0] prev,
  output step_e      cls,
  output logic [2:0] idx,
  output logic       onehot
);

  // Decode the current sample and compare it against the previous one.
  always_comb begin
    onehot = is_onehot(cur);
    idx    = onehot_idx(cur);
    if (cur == prev) begin
      cls = HOLD;
    end else if (cur == 6'd0 || prev == 6'd0) begin
      cls = BLANK;
    end else if (onehot && is_onehot(prev) && cur == rotl6(prev)) begin
      cls = FWD;
    end else if (onehot && is_onehot(prev) && cur == rotr6(prev)) begin
      cls = REV;
    end else begin
      cls = BAD;
    end
  end

endmodule

// File: rtl/seg_anim_monitor.sv
// Receive-side checker for the rotating A-F segment chase.
module seg_anim_monitor
  import seg_anim_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_STEPS = 3,
  parameter int unsigned TIMEOUT    = 50000
) (
  input logic clock,
  input logic reset,
  seg_anim_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  logic [5:0]       cur_q, prev_q;
  logic [CNT_W-1:0] dwell_q, dwell_d, period_q, period_d, dwell_inc;
  logic [2:0]       cnt_q, cnt_d, cnt_inc;
  logic             adir_q, adir_d;
  state_e           state_q, state_d;
  step_e            cls;
  logic [2:0]       idx;
  logic             onehot, is_step, step_cw;

  logic [2:0] position_q;
  logic       posvalid_q, strobe_q, dircw_q, locked_q, fault_q, stalled_q;

  seg_step_classifier u_cls (
    .cur    (cur_q),
    .prev   (prev_q),
    .cls    (cls),
    .idx    (idx),
    .onehot (onehot)
  );

  assign is_step   = (cls == FWD) || (cls == REV);
  assign step_cw   = (cls == FWD);
  assign dwell_inc = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_W'(1);
  assign cnt_inc   = cnt_q + 3'd1;

  // Sample the bus; prev keeps the last non-blank pattern so a step across blanks still counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= bus.io_segAtoF;
      prev_q <= (cur_q != 6'd0) ? cur_q : prev_q;
    end
  end

  // Dwell counter and step period; blanks keep counting.
  always_comb begin
    dwell_d  = dwell_inc;
    period_d = period_q;
    if (is_step) period_d = dwell_inc;
    if (is_step || (state_q == FAULT && bus.io_clearErr)) dwell_d = '0;
  end

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adir_d  = adir_q;
    unique case (state_q)
      IDLE: begin
        if (is_step) begin
          cnt_d   = 3'd1;
          adir_d  = step_cw;
          state_d = (LOCK_STEPS <= 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (cls == BAD) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (is_step && step_cw == adir_q) begin
          cnt_d = cnt_inc;
          if (32'(cnt_inc) >= LOCK_STEPS) state_d = LOCKED;
        end else if (is_step) begin
          cnt_d  = 3'd1;
          adir_d = step_cw;
        end
      end
      LOCKED: begin
        if (cls == BAD || (is_step && step_cw != adir_q)) state_d = FAULT;
      end
      FAULT: begin
        if (bus.io_clearErr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      adir_q     <= 1'b0;
      dwell_q    <= '0;
      period_q   <= '0;
      position_q <= '0;
      posvalid_q <= 1'b0;
      strobe_q   <= 1'b0;
      dircw_q    <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adir_q     <= adir_d;
      dwell_q    <= dwell_d;
      period_q   <= period_d;
      position_q <= onehot ? idx : 3'd0;
      posvalid_q <= onehot;
      strobe_q   <= is_step;
      dircw_q    <= is_step ? step_cw : dircw_q;
      locked_q   <= (state_d == LOCKED);
      fault_q    <= (state_d == FAULT);
      stalled_q  <= (state_d == LOCKED) && (dwell_d >= TO_CNT);
    end
  end

  assign bus.io_position   = position_q;
  assign bus.io_posValid   = posvalid_q;
  assign bus.io_stepStrobe = strobe_q;
  assign bus.io_dirCW      = dircw_q;
  assign bus.io_locked     = locked_q;
  assign bus.io_fault      = fault_q;
  assign bus.io_stalled    = stalled_q;
  assign bus.io_stepPeriod = period_q;

endmodule
